// File: rtl/cv32e41p_apu_responder_if.sv
// APU dispatcher <-> responder handshake bundle.
interface cv32e41p_apu_responder_if #(
    parameter int WIDTH = 32
);
    logic             apu_req_i;
    logic             apu_gnt_o;
    logic [1:0]       apu_op_i;
    logic [WIDTH-1:0] apu_opa_i;
    logic [WIDTH-1:0] apu_opb_i;
    logic             apu_rvalid_o;
    logic [WIDTH-1:0] apu_result_o;
    logic [1:0]       apu_flags_o;
    logic             busy_o;

    modport master (
        output apu_req_i, apu_op_i, apu_opa_i, apu_opb_i,
        input  apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, busy_o
    );

    modport slave (
        input  apu_req_i, apu_op_i, apu_opa_i, apu_opb_i,
        output apu_gnt_o, apu_rvalid_o, apu_result_o, apu_flags_o, busy_o
    );
endinterface

// File: rtl/cv32e41p_apu_responder.sv
// APU responder: ADD/SUB return in the acceptance cycle, MUL one cycle later,
// DIVU via a restoring divider taking WIDTH RUN cycles plus one DONE cycle.
// Grant rules guarantee a single result per cycle, in acceptance order.
module cv32e41p_apu_responder #(
    parameter int WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    cv32e41p_apu_responder_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_mul_v;
    logic [WIDTH-1:0] r_mul_res;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;
    logic             r_dz;

    logic             w_gnt;
    logic             w_acc;
    logic             w_fast;
    logic             w_done;
    logic             w_rv;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_res;
    logic [WIDTH:0]   w_sh;
    logic [WIDTH:0]   w_diff;

    // Single-cycle ops are refused while a MUL result occupies the return port;
    // everything is refused while the divider is busy.
    assign w_gnt  = bus.apu_req_i & (r_state == S_IDLE) & ~(~bus.apu_op_i[1] & r_mul_v);
    assign w_acc  = w_gnt & rst_ni;
    assign w_fast = w_acc & ~bus.apu_op_i[1];
    assign w_done = (r_state == S_DONE);

    assign w_sum  = bus.apu_op_i[0] ? (bus.apu_opa_i - bus.apu_opb_i)
                                    : (bus.apu_opa_i + bus.apu_opb_i);
    assign w_prod = bus.apu_opa_i * bus.apu_opb_i;

    // One restoring step: shift next dividend bit into the remainder, try subtract.
    // With a zero divisor every trial succeeds, yielding an all-ones quotient.
    assign w_sh   = {r_rem, r_quo[WIDTH-1]};
    assign w_diff = w_sh - {1'b0, r_div};

    assign w_rv   = w_fast | r_mul_v | w_done;

    // Return-port mux; the three sources are mutually exclusive by grant rules.
    always_comb begin
        w_res = '0;
        if (w_fast)       w_res = w_sum;
        else if (r_mul_v) w_res = r_mul_res;
        else if (w_done)  w_res = r_quo;
    end

    assign bus.apu_gnt_o    = w_gnt;
    assign bus.apu_rvalid_o = w_rv;
    assign bus.apu_result_o = w_res;
    assign bus.apu_flags_o  = {w_done & r_dz, w_rv & (w_res == '0)};
    assign bus.busy_o       = r_mul_v | (r_state != S_IDLE);

    // MUL stage register: captures the product on acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mul_v   <= 1'b0;
            r_mul_res <= '0;
        end else begin
            r_mul_v <= w_acc & (bus.apu_op_i == 2'b10);
            if (w_acc & (bus.apu_op_i == 2'b10)) r_mul_res <= w_prod;
        end
    end

    // DIVU FSM: IDLE loads operands, RUN does one quotient bit per cycle, DONE returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_div   <= '0;
            r_dz    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc & (bus.apu_op_i == 2'b11)) begin
                        r_state <= S_RUN;
                        r_cnt   <= CW'(WIDTH - 1);
                        r_quo   <= bus.apu_opa_i;
                        r_rem   <= '0;
                        r_div   <= bus.apu_opb_i;
                        r_dz    <= (bus.apu_opb_i == '0);
                    end
                end
                S_RUN: begin
                    if (!w_diff[WIDTH]) begin
                        r_rem <= w_diff[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem <= w_sh[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == '0) r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e41p_apu_responder.sv
// Scoreboard bench: stimulus predicts grant and pushes expected results with
// their due cycle; a negedge monitor pops and checks every return.
module tb_cv32e41p_apu_responder;
    localparam int W = 32;

    typedef struct {
        int           acc;
        int           due;
        logic [W-1:0] res;
        logic [1:0]   flg;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   mul_acc_cyc = -10;
    int   div_end = -10;

    cv32e41p_apu_responder_if #(.WIDTH(W)) bus ();

    cv32e41p_apu_responder #(.WIDTH(W)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Reference behaviour from the operation definitions.
    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [2*W-1:0] p;
        e.acc = 0; e.due = 0; e.flg = 2'b00;
        case (op)
            2'b00: e.res = a + b;
            2'b01: e.res = a - b;
            2'b10: begin p = a * b; e.res = p[W-1:0]; end
            default: begin
                if (b == 0) begin e.res = '1; e.flg[1] = 1'b1; end
                else e.res = a / b;
            end
        endcase
        e.flg[0] = (e.res == 0);
        return e;
    endfunction

    // Present a request and hold it until granted, checking the grant each cycle.
    task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit   eg;
        bit   done;
        exp_t e;
        done = 0;
        @(posedge clk_i); #1;
        bus.apu_req_i = 1'b1; bus.apu_op_i = op; bus.apu_opa_i = a; bus.apu_opb_i = b;
        for (int k = 0; k < 100 && !done; k++) begin
            #1;
            eg = !(cyc <= div_end) && !((op[1] == 1'b0) && (mul_acc_cyc == cyc - 1));
            chk("gnt", {63'd0, bus.apu_gnt_o}, {63'd0, eg});
            if (bus.apu_gnt_o) begin
                e = model(op, a, b);
                e.acc = cyc;
                case (op)
                    2'b10:   begin e.due = cyc + 1; mul_acc_cyc = cyc; end
                    2'b11:   begin e.due = cyc + W + 1; div_end = cyc + W + 1; end
                    default: e.due = cyc;
                endcase
                sb.push_back(e);
                done = 1;
            end else begin
                @(posedge clk_i); #1;
            end
        end
        if (!done) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    // Idle cycle with scrambled operand inputs to expose any late sampling.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_i); #1;
            bus.apu_req_i = 1'b0;
            bus.apu_op_i  = 2'($urandom_range(0, 3));
            bus.apu_opa_i = $urandom;
            bus.apu_opb_i = $urandom;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sb.size() != 0; k++) idle(1);
        idle(2);
    endtask

    // Monitor: busy prediction plus in-order result checking.
    always @(negedge clk_i) begin
        exp_t e;
        bit   eb;
        eb = 0;
        foreach (sb[i]) if (sb[i].acc < cyc && sb[i].due >= cyc) eb = 1;
        chk("busy", {63'd0, bus.busy_o}, {63'd0, eb});
        if (bus.apu_rvalid_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("ret_cycle", 64'(cyc), 64'(e.due));
                chk("result", {32'd0, bus.apu_result_o}, {32'd0, e.res});
                chk("flags", {62'd0, bus.apu_flags_o}, {62'd0, e.flg});
            end
        end else begin
            chk("idle_outputs", {30'd0, bus.apu_flags_o, bus.apu_result_o}, 64'd0);
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                chk("missing_rvalid", 64'(cyc), 64'(e.due));
            end
        end
    end

    initial begin
        logic [1:0] op;
        logic [W-1:0] a, b;
        bus.apu_req_i = 1'b0; bus.apu_op_i = 2'b00; bus.apu_opa_i = '0; bus.apu_opb_i = '0;
        // Reset state: grant follows request, no return, not busy.
        for (int i = 0; i < 4; i++) begin
            bus.apu_req_i = 1'b1; bus.apu_op_i = 2'(i); bus.apu_opa_i = 5; bus.apu_opb_i = 5;
            #1;
            chk("rst_gnt", {63'd0, bus.apu_gnt_o}, 64'd1);
            chk("rst_rvalid", {63'd0, bus.apu_rvalid_o}, 64'd0);
            chk("rst_out", {29'd0, bus.busy_o, bus.apu_flags_o, bus.apu_result_o}, 64'd0);
        end
        bus.apu_req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        send(2'b00, 32'h7FFF_FFFF, 32'h1);           // -> 0x80000000, flags 00
        send(2'b01, 32'd5, 32'd5);                   // -> 0, flags 01
        idle(1);
        send(2'b10, 32'd3, 32'd4);                   // back-to-back MULs
        send(2'b10, 32'h1_0000, 32'h1_0000);
        idle(1);
        send(2'b10, 32'd7, 32'd9);                   // MUL then ADD collision
        send(2'b00, 32'd1, 32'd2);
        idle(1);
        send(2'b10, 32'd6, 32'd6);                   // DIVU granted behind MUL
        send(2'b11, 32'd100, 32'd7);
        drain();

        // Reset mid-division abandons it.
        send(2'b11, 32'd9, 32'd0);
        idle(9);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        sb.delete(); div_end = -10; mul_acc_cyc = -10;
        idle(2);
        @(posedge clk_i); #1 rst_ni = 1'b1;
        idle(40);
        send(2'b11, 32'd9, 32'd0);                   // rerun: all-ones, flags 10
        drain();

        for (int n = 0; n < 200; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 3));
            if (op == 2'b11 && $urandom_range(0, 2) == 0) a = 32'($urandom_range(0, 1000));
            send(op, a, b);
            if ($urandom_range(0, 2) == 0) idle(32'($urandom_range(1, 2)));
        end
        drain();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
